dcache_port_arbiter: RTL

- Shares the single data-cache request port (cmd/addr/data in, respcyc/resp_data out) between N_REQ requesters: memory pipeline, page walker, flush engine.
- Sits between those requesters and the line data cache inside the core.
- Grants round-robin and keeps one request outstanding.
- Holds the cache command stable until the cache responds, then routes the response back to the owner.

---
 rtl/dcache_port_arbiter_if.sv | 29 ++
 rtl/dcache_port_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/dcache_port_arbiter_if.sv
// Requester-side and cache-side signal bundle for the data-cache port arbiter.
// The arbiter uses the master view; requesters and cache models use the slave view.
interface dcache_port_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int CMD_W = 2
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*CMD_W-1:0] req_cmd;
    logic [N_REQ*64-1:0]    req_addr;
    logic [N_REQ*64-1:0]    req_data;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       resp_valid;
    logic [63:0]            resp_data;
    logic [CMD_W-1:0]       ca_req_cmd;
    logic [63:0]            ca_req_addr;
    logic [63:0]            ca_req_data;
    logic                   ca_respcyc;
    logic [63:0]            ca_resp_data;

    modport master (
        input  req_valid, req_cmd, req_addr, req_data, ca_respcyc, ca_resp_data,
        output req_ready, resp_valid, resp_data, ca_req_cmd, ca_req_addr, ca_req_data
    );

    modport slave (
        output req_valid, req_cmd, req_addr, req_data, ca_respcyc, ca_resp_data,
        input  req_ready, resp_valid, resp_data, ca_req_cmd, ca_req_addr, ca_req_data
    );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing the single data-cache request port among N_REQ
// requesters. One request is outstanding at a time; the latched command is held
// towards the cache until it responds, and the response is routed to the owner.
module dcache_port_arbiter #(
    parameter int N_REQ   = 2,
    parameter int CMD_W   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    dcache_port_arbiter_if.master bus,
    output logic                  busy,
    output logic                  timeout_err
);
    localparam int PTR_W = (N_REQ > 2) ? 2 : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [PTR_W-1:0] r_rrPtr;
    logic [PTR_W-1:0] r_owner;
    logic [CMD_W-1:0] r_cmd;
    logic [63:0]      r_addr;
    logic [63:0]      r_data;
    logic [63:0]      r_respData;
    logic [N_REQ-1:0] r_respValid;
    logic [CNT_W-1:0] r_waitCnt;
    logic             r_timeoutErr;

    logic             w_anyValid;
    logic [PTR_W-1:0] w_grantIdx;
    logic [PTR_W:0]   w_cand;

    // Round-robin search: first valid requester at or after r_rrPtr, wrapping at N_REQ.
    // Iterating from the farthest candidate down lets the nearest one win.
    always_comb begin
        w_anyValid = 1'b0;
        w_grantIdx = '0;
        w_cand     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, r_rrPtr} + (PTR_W + 1)'(k);
            if (w_cand >= (PTR_W + 1)'(N_REQ)) begin
                w_cand = w_cand - (PTR_W + 1)'(N_REQ);
            end
            if (bus.req_valid[w_cand[PTR_W-1:0]]) begin
                w_anyValid = 1'b1;
                w_grantIdx = w_cand[PTR_W-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: grant from IDLE, wait for the cache in BUSY, one RESP cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyValid) w_nextState = BUSY;
            BUSY:    if (bus.ca_respcyc) w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Output logic: accept pulse in IDLE, latched command only while BUSY.
    always_comb begin
        bus.req_ready   = '0;
        bus.ca_req_cmd  = '0;
        bus.ca_req_addr = '0;
        bus.ca_req_data = '0;
        busy            = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_anyValid) begin
                    bus.req_ready = N_REQ'(1) << w_grantIdx;
                end
            end
            BUSY: begin
                bus.ca_req_cmd  = r_cmd;
                bus.ca_req_addr = r_addr;
                bus.ca_req_data = r_data;
            end
            default: ;
        endcase
    end

    assign bus.resp_valid = r_respValid;
    assign bus.resp_data  = r_respData;
    assign timeout_err    = r_timeoutErr;

    // Transaction datapath: latch the granted request, count wait cycles, capture the response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rrPtr      <= '0;
            r_owner      <= '0;
            r_cmd        <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_respData   <= '0;
            r_respValid  <= '0;
            r_waitCnt    <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_respValid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_anyValid) begin
                        r_owner   <= w_grantIdx;
                        r_cmd     <= bus.req_cmd[w_grantIdx*CMD_W +: CMD_W];
                        r_addr    <= bus.req_addr[w_grantIdx*64 +: 64];
                        r_data    <= bus.req_data[w_grantIdx*64 +: 64];
                        r_waitCnt <= '0;
                    end
                end
                BUSY: begin
                    if (r_waitCnt != CNT_W'(TIMEOUT)) begin
                        r_waitCnt <= r_waitCnt + CNT_W'(1);
                    end
                    if (r_waitCnt >= CNT_W'(TIMEOUT - 1)) begin
                        r_timeoutErr <= 1'b1;
                    end
                    if (bus.ca_respcyc) begin
                        r_respData  <= bus.ca_resp_data;
                        r_respValid <= N_REQ'(1) << r_owner;
                        if (r_owner == PTR_W'(N_REQ - 1)) begin
                            r_rrPtr <= '0;
                        end else begin
                            r_rrPtr <= r_owner + PTR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
